fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of instruction entries (power of two, at least 2).
REQ-002 The block SHALL have parameter XLEN, default 32, meaning the PC and instruction width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  fetch stage presents a fetched instruction.
REQ-006 in_pc  input  XLEN  PC of the fetched instruction (the PC register output).
REQ-007 in_instr  input  XLEN  instruction word read from instruction memory.
REQ-008 pc_write  output  1  PC register write enable; 1 means the PC may advance.
REQ-009 flush  input  1  branch or jump redirect; discard all buffered instructions.
REQ-010 out_valid  output  1  decode-side entry valid.
REQ-011 out_ready  input  1  decode stage accepts the entry.
REQ-012 out_pc  output  XLEN  PC of the head entry.
REQ-013 out_instr  output  XLEN  instruction of the head entry.
REQ-014 out_misaligned  output  1  head entry PC has bits [1:0] nonzero.
REQ-015 count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Storage SHALL be a circular FIFO with read and write pointers of clog2(DEPTH) bits each, and pointers SHALL wrap from DEPTH-1 to 0.
REQ-017 pc_write SHALL equal (count != DEPTH); it SHALL be combinational from the state only and SHALL NOT depend on out_ready.
REQ-018 A push SHALL occur on a clock edge when in_valid=1, pc_write=1, flush=0, and no bypass takes place.
REQ-019 A pop SHALL occur on a clock edge when out_valid=1, out_ready=1, flush=0, and the entry comes from storage.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 When full, in_valid=1 SHALL be ignored, pc_write SHALL be 0, and a pop in that cycle SHALL make pc_write=1 in the next cycle.
REQ-022 out_valid SHALL equal (count != 0) AND NOT flush, subject to the bypass case in REQ-035.
REQ-023 When out_valid=0, out_pc, out_instr and out_misaligned SHALL be driven to 0.
REQ-024 The misaligned flag SHALL be computed as (in_pc[1:0] != 0) at push time and stored with the entry.
REQ-025 When flush=1, the next edge SHALL set count and both pointers to 0, and any in_valid in the same cycle SHALL be dropped.
REQ-026 No pop SHALL be reported to decode during a flush cycle.
REQ-027 Without the bypass feature, latency from push to out_valid SHALL be exactly 1 cycle.
REQ-028 Order SHALL be strictly FIFO, and no entry SHALL be duplicated or lost except by flush.

Reset
REQ-029 While reset=1, count SHALL be 0, both pointers SHALL be 0, and the storage valid state SHALL be empty, asynchronously.
REQ-030 During and immediately after reset, outputs SHALL be out_valid=0, out_pc=0, out_instr=0, out_misaligned=0, count=0, pc_write=1.
REQ-031 Reset asserted mid-operation SHALL discard all entries, and no partial push or pop SHALL be observable afterward.
REQ-032 Storage array contents SHALL NOT require reset.

Configuration
REQ-033 Macro FETCH_BUFFER_BYPASS_EN SHALL select a zero-latency bypass path.
REQ-034 Without FETCH_BUFFER_BYPASS_EN, behaviour SHALL be exactly REQ-016 to REQ-028.
REQ-035 With FETCH_BUFFER_BYPASS_EN, when count=0, in_valid=1, flush=0 and out_ready=1, the block SHALL drive out_valid=1, out_pc=in_pc, out_instr=in_instr and out_misaligned from in_pc in the same cycle, with no push.
REQ-036 With FETCH_BUFFER_BYPASS_EN, when count=0, in_valid=1 and out_ready=0, the block SHALL perform a normal push.

Verification
REQ-037 Reset, then push PC 0x0, 0x4, 0x8 with out_ready=0 -> count=3, pc_write=1, out_pc=0x0.
REQ-038 Fill all 4 entries, then hold in_valid=1 with PC 0x10 -> pc_write=0, entry 0x10 not stored; pop once -> pc_write=1 on the next cycle.
REQ-039 With count=2, push and pop on the same edge -> count stays 2, and out_pc advances to the second-oldest PC.
REQ-040 With count=3, assert flush together with in_valid (PC 0x40) -> next cycle count=0, out_valid=0, and 0x40 absent.
REQ-041 Push PC 0x6 -> out_misaligned=1 when that entry is at the head; push PC 0x8 -> out_misaligned=0.
REQ-042 With the macro defined, count=0, in_valid=1 (PC 0x20, instr 0x00000013) and out_ready=1 -> out_valid=1 in the same cycle with out_pc=0x20 and count stays 0; with the macro undefined -> out_valid=0 that cycle, then 1 the next cycle.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: fetch-side and decode-side handshake bundle of the fetch buffer
interface fetch_buffer_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            pc_write;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_misaligned;
  modport master (output in_valid, in_pc, in_instr, flush, out_ready,
                  input  pc_write, out_valid, out_pc, out_instr, out_misaligned);
  modport slave  (input  in_valid, in_pc, in_instr, flush, out_ready,
                  output pc_write, out_valid, out_pc, out_instr, out_misaligned);
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular instruction FIFO between fetch and decode; FETCH_BUFFER_BYPASS_EN adds a zero-latency bypass when empty
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  fetch_buffer_if.slave            bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic            mis_mem   [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            byp, head_valid, push, pop;
`ifdef FETCH_BUFFER_BYPASS_EN
  assign byp = count == '0 && bus.in_valid && !bus.flush && bus.out_ready;
`else
  assign byp = 1'b0;
`endif
  always_comb begin
    bus.pc_write       = count != (AW+1)'(DEPTH);
    head_valid         = count != '0 && !bus.flush;
    push               = bus.in_valid && bus.pc_write && !bus.flush && !byp;
    pop                = head_valid && bus.out_ready;
    bus.out_valid      = head_valid || byp;
    bus.out_pc         = head_valid ? pc_mem[rd_ptr]    : byp ? bus.in_pc    : '0;
    bus.out_instr      = head_valid ? instr_mem[rd_ptr] : byp ? bus.in_instr : '0;
    bus.out_misaligned = head_valid ? mis_mem[rd_ptr]   : byp && bus.in_pc[1:0] != 2'b00;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= pop  ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // payload storage carries no reset; validity lives in count
  always_ff @(posedge clk)
    if (push && !reset) begin
      pc_mem[wr_ptr]    <= bus.in_pc;
      instr_mem[wr_ptr] <= bus.in_instr;
      mis_mem[wr_ptr]   <= bus.in_pc[1:0] != 2'b00;
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: random and directed checks of fetch_buffer against a queue model
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [$clog2(DEPTH):0] count;
  always #5 clk = ~clk;
  fetch_buffer_if #(.XLEN(XLEN)) bus ();
  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus), .count(count));
  typedef struct {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;} ent_t;
  ent_t q[$];
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  // model evaluates the queue against current inputs just before each rising edge, then advances
  always @(negedge clk) begin
    bit byp, hv, pcw;
    logic [XLEN-1:0] epc, ein;
    if (reset) begin
      q.delete();
      chk("rst_count", count, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_pc", bus.out_pc, 0);
      chk("rst_pcw", bus.pc_write, 1);
    end else begin
      pcw = q.size() != DEPTH;
      hv  = q.size() != 0 && !bus.flush;
      byp = BYP && q.size() == 0 && bus.in_valid && !bus.flush && bus.out_ready;
      epc = hv ? q[0].pc    : byp ? bus.in_pc    : '0;
      ein = hv ? q[0].instr : byp ? bus.in_instr : '0;
      chk("count", count, q.size());
      chk("pc_write", bus.pc_write, pcw);
      chk("out_valid", bus.out_valid, hv || byp);
      chk("out_pc", bus.out_pc, epc);
      chk("out_instr", bus.out_instr, ein);
      chk("out_misaligned", bus.out_misaligned, epc[1:0] != 2'b00);
      if (bus.flush) q.delete();
      else begin
        if (hv && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && pcw && !byp) q.push_back('{bus.in_pc, bus.in_instr});
      end
    end
  end
  task automatic drive(input bit iv, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr,
                       input bit fl, input bit rdy);
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = instr;
    bus.flush     = fl;
    bus.out_ready = rdy;
  endtask
  initial begin
    bus.in_valid = 0; bus.in_pc = '0; bus.in_instr = '0; bus.flush = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc_write", bus.pc_write, 1);
    chk("reset_misaligned", bus.out_misaligned, 0);
    #2 reset = 1'b0;
    drive(1, 32'h0, 32'hA0, 0, 0);
    drive(1, 32'h4, 32'hA4, 0, 0);
    drive(1, 32'h8, 32'hA8, 0, 0);
    drive(0, 0, 0, 0, 0); #1;
    chk("three_count", count, 3);
    chk("three_pcw", bus.pc_write, 1);
    chk("three_head", bus.out_pc, 32'h0);
    drive(1, 32'hC, 32'hAC, 0, 0);
    drive(1, 32'h10, 32'hB0, 0, 0); #1;
    chk("full_pcw", bus.pc_write, 0);
    chk("full_count", count, 4);
    drive(1, 32'h10, 32'hB0, 0, 1); #1;
    chk("full_pop_pcw_same", bus.pc_write, 0);
    drive(0, 0, 0, 0, 0); #1;
    chk("after_pop_pcw", bus.pc_write, 1);
    chk("after_pop_count", count, 3);
    chk("after_pop_head", bus.out_pc, 32'h4);
    drive(0, 0, 0, 0, 1);
    drive(1, 32'h14, 32'hB4, 0, 1);
    drive(0, 0, 0, 0, 0); #1;
    chk("pushpop_count", count, 2);
    chk("pushpop_head", bus.out_pc, 32'hC);
    drive(1, 32'h18, 32'hB8, 0, 0);
    drive(1, 32'h40, 32'hC0, 1, 1); #1;
    chk("flush_cycle_valid", bus.out_valid, 0);
    drive(0, 0, 0, 0, 0); #1;
    chk("flush_count", count, 0);
    chk("flush_valid", bus.out_valid, 0);
    drive(1, 32'h6, 32'hD6, 0, 0);
    drive(1, 32'h8, 32'hD8, 0, 0);
    drive(0, 0, 0, 0, 0); #1;
    chk("mis_head_pc", bus.out_pc, 32'h6);
    chk("mis_head_flag", bus.out_misaligned, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0); #1;
    chk("aligned_head_pc", bus.out_pc, 32'h8);
    chk("aligned_head_flag", bus.out_misaligned, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(1, 32'h20, 32'h13, 0, 1); #1;
    chk("byp_same_valid", bus.out_valid, BYP);
    chk("byp_same_pc", bus.out_pc, BYP ? 32'h20 : 32'h0);
    drive(0, 0, 0, 0, 1); #1;
    chk("byp_next_valid", bus.out_valid, !BYP);
    chk("byp_next_count", count, BYP ? 0 : 1);
    drive(1, 32'h30, 32'hE0, 0, 0);
    drive(1, 32'h34, 32'hE4, 0, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_valid", bus.out_valid, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (3000)
      drive($urandom_range(3) != 0, $urandom, $urandom, $urandom_range(15) == 0, $urandom_range(2) != 0);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
